// File: rtl/round_from_zero.sv
// Registered signed requantizer: clears the NBITS LSBs of a DIN-bit word, rounding away from zero,
// behind a 2-entry skid buffer (out register + skid register) with registered ready.
module round_from_zero #(
    parameter int DIN      = 16,
    parameter int NBITS    = 1,
    parameter int SATURATE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DIN-1:0] din_data,
    input  logic           din_valid,
    output logic           din_ready,
    output logic [DIN-1:0] dout_data,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic           ovf
);

    localparam logic signed [DIN:0] RND_ADD  = {{(DIN+1-NBITS){1'b0}}, {NBITS{1'b1}}};
    localparam logic [DIN-1:0]      LOW_MASK = {{(DIN-NBITS){1'b0}}, {NBITS{1'b1}}};
    localparam logic [DIN-1:0]      SAT_VAL  = {1'b0, {(DIN-1-NBITS){1'b1}}, {NBITS{1'b0}}};

    // Returns {ovf, rounded word}. Non-negative words get the rounding bias; negative words
    // are simply truncated, which floors them and so moves them away from zero.
    function automatic logic [DIN:0] round_away(input logic signed [DIN-1:0] x);
        logic signed [DIN:0] xe;
        logic signed [DIN:0] s;
        logic [DIN-1:0]      r;
        logic                o;
        xe = {x[DIN-1], x};
        s  = x[DIN-1] ? xe : xe + RND_ADD;
        o  = !x[DIN-1] && s[DIN-1];
        r  = s[DIN-1:0] & ~LOW_MASK;
        if (o && SATURATE != 0)
            r = SAT_VAL;
        return {o, r};
    endfunction

    logic signed [DIN-1:0] rnd_data_p0;
    logic                  rnd_ovf_p0;
    logic signed [DIN-1:0] out_data_p1;
    logic                  out_ovf_p1;
    logic                  out_vld_p1;
    logic signed [DIN-1:0] skid_data_p1;
    logic                  skid_ovf_p1;
    logic                  skid_vld_p1;
    logic                  rdy_p1;

    logic accept;
    logic stall;
    logic skid_nxt;

    // Stage p0: combinational rounding of the incoming word
    always_comb begin
        {rnd_ovf_p0, rnd_data_p0} = round_away(din_data);
    end

    assign accept = din_valid && rdy_p1;
    assign stall  = out_vld_p1 && !dout_ready;

    always_comb begin
        skid_nxt = 1'b0;
        if (stall)
            skid_nxt = skid_vld_p1 || accept;
    end

    // Stage p1: output register, skid register and registered ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld_p1  <= 1'b0;
            out_data_p1 <= '0;
            out_ovf_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b0;
        end else begin
            rdy_p1      <= !skid_nxt;
            skid_vld_p1 <= skid_nxt;
            if (!stall) begin
                if (skid_vld_p1) begin
                    out_data_p1 <= skid_data_p1;
                    out_ovf_p1  <= skid_ovf_p1;
                    out_vld_p1  <= 1'b1;
                end else begin
                    out_vld_p1 <= accept;
                    if (accept) begin
                        out_data_p1 <= rnd_data_p0;
                        out_ovf_p1  <= rnd_ovf_p0;
                    end
                end
            end
        end
    end

    // Skid payload only matters while skid_vld_p1 is set, so it carries no reset
    always_ff @(posedge clk) begin
        if (accept && stall) begin
            skid_data_p1 <= rnd_data_p0;
            skid_ovf_p1  <= rnd_ovf_p0;
        end
    end

    assign din_ready  = rdy_p1;
    assign dout_valid = out_vld_p1;
    assign dout_data  = out_data_p1;
    assign ovf        = out_ovf_p1;

endmodule

// File: tb/tb_round_from_zero.sv
// Bench for round_from_zero (DIN=16, NBITS=4): saturating and wrapping instances side by side,
// directed vectors, stall/skid behaviour, randomized traffic against an integer reference model, async reset.
module tb_round_from_zero;

    localparam int DIN = 16;
    localparam int NB  = 4;

    logic           clk;
    logic           rst;
    logic [DIN-1:0] din_data;
    logic           din_valid;
    logic           dout_ready;
    logic           din_ready,   w_din_ready;
    logic [DIN-1:0] dout_data,   w_dout_data;
    logic           dout_valid,  w_dout_valid;
    logic           ovf,         w_ovf;

    int vectors = 0;
    int errors  = 0;

    round_from_zero #(.DIN(DIN), .NBITS(NB), .SATURATE(1)) dut (
        .clk(clk), .rst(rst),
        .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .ovf(ovf)
    );

    round_from_zero #(.DIN(DIN), .NBITS(NB), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst),
        .din_data(din_data), .din_valid(din_valid), .din_ready(w_din_ready),
        .dout_data(w_dout_data), .dout_valid(w_dout_valid), .dout_ready(dout_ready),
        .ovf(w_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: round magnitude up to a multiple of 2^NB with plain integer arithmetic
    function automatic void model(input logic [DIN-1:0] d, output logic [DIN-1:0] sat,
                                  output logic [DIN-1:0] wrp, output logic o);
        int x;
        int q;
        int step;
        int maxpos;
        step   = 1 << NB;
        maxpos = (1 << (DIN-1)) - 1;
        x = int'($signed(d));
        if (x >= 0) q = ((x + step - 1) / step) * step;
        else        q = -(((-x) + step - 1) / step) * step;
        o   = (q > maxpos);
        wrp = q[DIN-1:0];
        sat = o ? DIN'((1 << (DIN-1)) - step) : q[DIN-1:0];
    endfunction

    // Drive inputs just after a rising edge, return at the following falling edge
    task automatic drive(input logic v, input logic [DIN-1:0] d, input logic r);
        @(posedge clk);
        #1;
        din_valid  = v;
        din_data   = d;
        dout_ready = r;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; din_valid = 1'b0; din_data = '0; dout_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (dout_valid !== 1'b0 || dout_data !== '0 || ovf !== 1'b0 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h ovf=%b ready=%b, required 0 0000 0 0",
                     dout_valid, dout_data, ovf, din_ready);
        end
        #2 rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b, required 1 0", din_ready, dout_valid);
        end
    endtask

    task automatic test_directed;
        logic [DIN-1:0] din_t [11] = '{16'h0011, 16'h0010, 16'h0000, 16'hFFEF, 16'hFFF0, 16'h8001,
                                       16'h7FF1, 16'h7FF0, 16'h7FFF, 16'hFFFF, 16'h0001};
        logic [DIN-1:0] sat_t [11] = '{16'h0020, 16'h0010, 16'h0000, 16'hFFE0, 16'hFFF0, 16'h8000,
                                       16'h7FF0, 16'h7FF0, 16'h7FF0, 16'hFFF0, 16'h0010};
        logic [DIN-1:0] wrp_t [11] = '{16'h0020, 16'h0010, 16'h0000, 16'hFFE0, 16'hFFF0, 16'h8000,
                                       16'h8000, 16'h7FF0, 16'h8000, 16'hFFF0, 16'h0010};
        logic           ovf_t [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
        for (int i = 0; i <= 11; i++) begin
            drive(i < 11, (i < 11) ? din_t[i] : 16'h0, 1'b1);
            if (i > 0) begin
                vectors++;
                if (dout_valid !== 1'b1 || dout_data !== sat_t[i-1] || ovf !== ovf_t[i-1]) begin
                    errors++;
                    $display("FAIL directed_sat[%0d] din=%h: got v=%b %h ovf=%b, required 1 %h ovf=%b",
                             i-1, din_t[i-1], dout_valid, dout_data, ovf, sat_t[i-1], ovf_t[i-1]);
                end
                vectors++;
                if (w_dout_valid !== 1'b1 || w_dout_data !== wrp_t[i-1] || w_ovf !== ovf_t[i-1]) begin
                    errors++;
                    $display("FAIL directed_wrap[%0d] din=%h: got v=%b %h ovf=%b, required 1 %h ovf=%b",
                             i-1, din_t[i-1], w_dout_valid, w_dout_data, w_ovf, wrp_t[i-1], ovf_t[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall;
        int idx = 0, nout = 0, acc_stall = 0;
        logic held = 1'b0;
        logic [DIN-1:0] held_data = '0;
        for (int cyc = 0; cyc < 30 && nout < 6; cyc++) begin
            drive(idx < 6, DIN'(idx + 1), cyc >= 3);
            if (cyc == 2) begin
                vectors++;
                if (din_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: din_ready=%b during stall, required 0", din_ready);
                end
            end
            if (held) begin
                vectors++;
                if (dout_valid !== 1'b1 || dout_data !== held_data) begin
                    errors++;
                    $display("FAIL stall_hold: v=%b data=%h, required 1 %h", dout_valid, dout_data, held_data);
                end
            end
            if (cyc >= 3) begin
                vectors++;
                if (dout_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_bubble: cycle %0d dout_valid=%b, required 1", cyc, dout_valid);
                end
            end
            if (din_valid && din_ready) begin
                idx++;
                if (cyc < 3) acc_stall++;
            end
            held = dout_valid && !dout_ready;
            held_data = dout_data;
            if (dout_valid && dout_ready) begin
                vectors++;
                if (dout_data !== 16'h0010 || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_data[%0d]: got %h ovf=%b, required 0010 ovf=0", nout, dout_data, ovf);
                end
                nout++;
            end
        end
        vectors++;
        if (acc_stall != 2 || nout != 6) begin
            errors++;
            $display("FAIL stall_count: accepted during stall=%0d out=%0d, required 2 and 6", acc_stall, nout);
        end
        drive(1'b0, '0, 1'b1);
    endtask

    task automatic test_random;
        logic [DIN-1:0] q_sat[$];
        logic [DIN-1:0] q_wrp[$];
        logic           q_ovf[$];
        logic [DIN-1:0] es, ew, d;
        logic           eo, v, held, held_ovf;
        logic [DIN-1:0] held_data;
        int nin = 0, nout = 0;
        held = 1'b0; held_ovf = 1'b0; held_data = '0;
        for (int cyc = 0; cyc < 60000 && nout < 10000; cyc++) begin
            case ($urandom_range(3))
                0:       d = DIN'(16'h7FF0 + $urandom_range(15));
                1:       d = DIN'(16'h8000 + $urandom_range(31));
                default: d = DIN'($urandom);
            endcase
            v = (nin < 10000) && ($urandom_range(1) == 1);
            drive(v, d, $urandom_range(1) == 1);
            if (held) begin
                vectors++;
                if (dout_valid !== 1'b1 || dout_data !== held_data || ovf !== held_ovf) begin
                    errors++;
                    $display("FAIL random_hold: v=%b %h ovf=%b, required 1 %h ovf=%b",
                             dout_valid, dout_data, ovf, held_data, held_ovf);
                end
            end
            if (din_valid && din_ready) begin
                model(din_data, es, ew, eo);
                q_sat.push_back(es); q_wrp.push_back(ew); q_ovf.push_back(eo);
                nin++;
            end
            held = dout_valid && !dout_ready;
            held_data = dout_data;
            held_ovf = ovf;
            if (dout_valid && dout_ready) begin
                vectors++;
                if (q_sat.size() == 0) begin
                    errors++;
                    $display("FAIL random_extra: output %h with nothing outstanding", dout_data);
                end else begin
                    es = q_sat.pop_front(); ew = q_wrp.pop_front(); eo = q_ovf.pop_front();
                    if (dout_data !== es || ovf !== eo || w_dout_valid !== 1'b1 ||
                        w_dout_data !== ew || w_ovf !== eo) begin
                        errors++;
                        $display("FAIL random_data[%0d]: sat %h/%b wrap %b %h/%b, required %h/%b wrap 1 %h/%b",
                                 nout, dout_data, ovf, w_dout_valid, w_dout_data, w_ovf, es, eo, ew, eo);
                    end
                end
                nout++;
            end
        end
        vectors++;
        if (nout != 10000 || q_sat.size() != 0) begin
            errors++;
            $display("FAIL random_count: out=%0d outstanding=%0d, required 10000 and 0", nout, q_sat.size());
        end
        drive(1'b0, '0, 1'b1);
    endtask

    task automatic test_async_reset;
        drive(1'b1, 16'h0100, 1'b0);
        drive(1'b1, 16'h0200, 1'b0);
        @(posedge clk);
        #1 din_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b0 || ovf !== 1'b0 || dout_data !== '0) begin
            errors++;
            $display("FAIL async_reset: v=%b ready=%b ovf=%b data=%h, required 0 0 0 0000",
                     dout_valid, din_ready, ovf, dout_data);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        drive(1'b1, 16'h0021, 1'b1);
        vectors++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ready: ready=%b v=%b, required 1 0", din_ready, dout_valid);
        end
        drive(1'b0, '0, 1'b1);
        vectors++;
        if (dout_valid !== 1'b1 || dout_data !== 16'h0030 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_word: v=%b %h ovf=%b, required 1 0030 0", dout_valid, dout_data, ovf);
        end
        drive(1'b0, '0, 1'b1);
        vectors++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_stale: dout_valid=%b data=%h, required 0", dout_valid, dout_data);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_stall;
        test_random;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
